// File: rtl/controller_sequencer_if.sv
// Bundle between the ring counter / instruction register and the SAP-1 control sequencer.
// Timing states and opcode flow master->slave; control word and status flow slave->master.
interface controller_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             t1, t2, t3, t4, t5, t6;
    logic [3:0]       ir_opcode;
    logic             cp, ep, lm, ce;
    logic             li, ei, la, ea;
    logic             su, eu, lb, lo;
    logic             hlt;
    logic             seq_err;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output t1, t2, t3, t4, t5, t6, ir_opcode,
        input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo,
        input  hlt, seq_err, illegal_op, instr_count
    );

    modport slave (
        input  t1, t2, t3, t4, t5, t6, ir_opcode,
        output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo,
        output hlt, seq_err, illegal_op, instr_count
    );
endinterface

// File: rtl/controller_sequencer.sv
// SAP-1 control sequencer: decodes ring-counter states and opcode into the control word,
// and owns the halt latch, ring-sequence monitor, illegal-opcode flag and retired count.
module controller_sequencer #(
    parameter int CNT_W    = 8,
    parameter bit CHECK_EN = 1'b1
) (
    input logic                   clock,
    input logic                   clr,
    controller_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // Control word bit order: cp ep lm ce li ei la ea su eu lb lo
    localparam logic [11:0] CW_CP = 12'h800;
    localparam logic [11:0] CW_EP = 12'h400;
    localparam logic [11:0] CW_LM = 12'h200;
    localparam logic [11:0] CW_CE = 12'h100;
    localparam logic [11:0] CW_LI = 12'h080;
    localparam logic [11:0] CW_EI = 12'h040;
    localparam logic [11:0] CW_LA = 12'h020;
    localparam logic [11:0] CW_EA = 12'h010;
    localparam logic [11:0] CW_SU = 12'h008;
    localparam logic [11:0] CW_EU = 12'h004;
    localparam logic [11:0] CW_LB = 12'h002;
    localparam logic [11:0] CW_LO = 12'h001;

    logic             halted;
    logic             seq_err_r;
    logic             illegal_r;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       prev;
    logic             prev_valid;

    logic [5:0]       tv;
    logic             tv_onehot;
    logic [5:0]       tv_expected;
    logic             op_known;
    logic [11:0]      cw;

    assign tv          = {bus.t6, bus.t5, bus.t4, bus.t3, bus.t2, bus.t1};
    assign tv_onehot   = (tv != '0) && ((tv & (tv - 6'd1)) == '0);
    assign tv_expected = prev_valid ? {prev[4:0], prev[5]} : 6'b000001;
    assign op_known    = bus.ir_opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT};

    always_comb begin
        cw = '0;
        if (!clr && !halted && tv_onehot) begin
            case (tv)
                6'b000001: cw = CW_EP | CW_LM;
                6'b000010: cw = CW_CP;
                6'b000100: cw = CW_CE | CW_LI;
                6'b001000: begin
                    case (bus.ir_opcode)
                        OP_LDA, OP_ADD, OP_SUB: cw = CW_EI | CW_LM;
                        OP_OUT:                 cw = CW_EA | CW_LO;
                        default:                cw = '0;
                    endcase
                end
                6'b010000: begin
                    case (bus.ir_opcode)
                        OP_LDA:         cw = CW_CE | CW_LA;
                        OP_ADD, OP_SUB: cw = CW_CE | CW_LB;
                        default:        cw = '0;
                    endcase
                end
                6'b100000: begin
                    case (bus.ir_opcode)
                        OP_ADD:  cw = CW_EU | CW_LA;
                        OP_SUB:  cw = CW_EU | CW_LA | CW_SU;
                        default: cw = '0;
                    endcase
                end
                default: cw = '0;
            endcase
        end
    end

    assign {bus.cp, bus.ep, bus.lm, bus.ce, bus.li, bus.ei,
            bus.la, bus.ea, bus.su, bus.eu, bus.lb, bus.lo} = cw;

    // All updates use pre-edge state, so a halting T4 is still sequence-checked.
    always_ff @(posedge clock) begin
        if (clr) begin
            halted     <= 1'b0;
            seq_err_r  <= 1'b0;
            illegal_r  <= 1'b0;
            cnt        <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (!halted) begin
            if (bus.t4 && (bus.ir_opcode == OP_HLT))
                halted <= 1'b1;
            if (bus.t4 && !op_known)
                illegal_r <= 1'b1;
            if (bus.t6)
                cnt <= cnt + CNT_W'(1);
            if (CHECK_EN) begin
                if (!tv_onehot || (tv != tv_expected))
                    seq_err_r <= 1'b1;
                prev       <= tv;
                prev_valid <= 1'b1;
            end
        end
    end

    assign bus.hlt         = halted;
    assign bus.seq_err     = CHECK_EN ? seq_err_r : 1'b0;
    assign bus.illegal_op  = illegal_r;
    assign bus.instr_count = cnt;
endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for controller_sequencer: ring states driven on negedge, control word
// checked mid-cycle, registered status checked just after each posedge.
module tb_controller_sequencer;
    localparam logic [11:0] W_T1  = 12'h600;
    localparam logic [11:0] W_T2  = 12'h800;
    localparam logic [11:0] W_T3  = 12'h180;
    localparam logic [11:0] W_LD4 = 12'h240;
    localparam logic [11:0] W_LD5 = 12'h120;
    localparam logic [11:0] W_AD5 = 12'h102;
    localparam logic [11:0] W_AD6 = 12'h024;
    localparam logic [11:0] W_SB6 = 12'h02C;
    localparam logic [11:0] W_OU4 = 12'h011;

    logic clock;
    logic clr;
    int   checks;
    int   errors;
    logic [11:0] cw;

    controller_sequencer_if #(.CNT_W(8)) bus ();

    controller_sequencer #(.CNT_W(8), .CHECK_EN(1'b1)) dut (
        .clock (clock),
        .clr   (clr),
        .bus   (bus.slave)
    );

    assign cw = {bus.cp, bus.ep, bus.lm, bus.ce, bus.li, bus.ei,
                 bus.la, bus.ea, bus.su, bus.eu, bus.lb, bus.lo};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] tv, input logic [3:0] op);
        @(negedge clock);
        clr = 1'b0;
        {bus.t6, bus.t5, bus.t4, bus.t3, bus.t2, bus.t1} = tv;
        bus.ir_opcode = op;
    endtask

    task automatic edge_wait();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        clr = 1'b1;
        {bus.t6, bus.t5, bus.t4, bus.t3, bus.t2, bus.t1} = 6'b000000;
        edge_wait();
    endtask

    task automatic instr(input string tag, input logic [3:0] op,
                         input logic [11:0] w4, input logic [11:0] w5, input logic [11:0] w6);
        logic [11:0] w [6];
        w[0] = W_T1; w[1] = W_T2; w[2] = W_T3; w[3] = w4; w[4] = w5; w[5] = w6;
        for (int k = 0; k < 6; k++) begin
            drive(6'(1 << k), op);
            #1 chk($sformatf("%s_T%0d", tag, k + 1), 32'(cw), 32'(w[k]));
            edge_wait();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr = 1'b1;
        {bus.t6, bus.t5, bus.t4, bus.t3, bus.t2, bus.t1} = 6'b000001;
        bus.ir_opcode = 4'h0;
        edge_wait();
        edge_wait();
        chk("cw_during_clr", 32'(cw), 32'h0);
        chk("rst_hlt", 32'(bus.hlt), 32'h0);
        chk("rst_seq_err", 32'(bus.seq_err), 32'h0);
        chk("rst_illegal", 32'(bus.illegal_op), 32'h0);
        chk("rst_count", 32'(bus.instr_count), 32'h0);
        do_reset();

        instr("lda", 4'h0, W_LD4, W_LD5, 12'h000);
        chk("lda_count", 32'(bus.instr_count), 32'd1);
        chk("lda_seq_err", 32'(bus.seq_err), 32'h0);
        instr("add", 4'h1, W_LD4, W_AD5, W_AD6);
        chk("add_count", 32'(bus.instr_count), 32'd2);
        instr("sub", 4'h2, W_LD4, W_AD5, W_SB6);
        chk("sub_count", 32'(bus.instr_count), 32'd3);
        instr("out", 4'hE, W_OU4, 12'h000, 12'h000);
        chk("out_count", 32'(bus.instr_count), 32'd4);
        chk("pre_illegal", 32'(bus.illegal_op), 32'h0);
        instr("ill", 4'h5, 12'h000, 12'h000, 12'h000);
        chk("ill_flag", 32'(bus.illegal_op), 32'h1);
        chk("ill_count", 32'(bus.instr_count), 32'd5);
        instr("lda2", 4'h0, W_LD4, W_LD5, 12'h000);
        chk("ill_sticky", 32'(bus.illegal_op), 32'h1);
        chk("lda2_count", 32'(bus.instr_count), 32'd6);

        // HLT: halted registers on the T4 edge
        drive(6'b000001, 4'hF); #1 chk("hlt_T1", 32'(cw), 32'(W_T1)); edge_wait();
        drive(6'b000010, 4'hF); #1 chk("hlt_T2", 32'(cw), 32'(W_T2)); edge_wait();
        drive(6'b000100, 4'hF); #1 chk("hlt_T3", 32'(cw), 32'(W_T3)); edge_wait();
        drive(6'b001000, 4'hF); #1 chk("hlt_T4", 32'(cw), 32'h0);
        chk("hlt_before_edge", 32'(bus.hlt), 32'h0);
        edge_wait();
        chk("hlt_after_edge", 32'(bus.hlt), 32'h1);
        drive(6'b010000, 4'hF); #1 chk("halted_T5", 32'(cw), 32'h0); edge_wait();
        drive(6'b100000, 4'hF); #1 chk("halted_T6", 32'(cw), 32'h0); edge_wait();
        chk("halted_count", 32'(bus.instr_count), 32'd6);
        drive(6'b000001, 4'h0); #1 chk("halted_T1", 32'(cw), 32'h0); edge_wait();
        drive(6'b000010, 4'h0); #1 chk("halted_T2", 32'(cw), 32'h0); edge_wait();
        chk("halted_hold", 32'(bus.hlt), 32'h1);
        chk("halted_count2", 32'(bus.instr_count), 32'd6);
        chk("halted_seq", 32'(bus.seq_err), 32'h0);
        do_reset();
        chk("clr_hlt", 32'(bus.hlt), 32'h0);
        chk("clr_count", 32'(bus.instr_count), 32'h0);
        chk("clr_illegal", 32'(bus.illegal_op), 32'h0);

        // Skipped state: t1 then t3
        drive(6'b000001, 4'h0); edge_wait();
        chk("skip_first_ok", 32'(bus.seq_err), 32'h0);
        drive(6'b000100, 4'h0); #1 chk("skip_cw_T3", 32'(cw), 32'(W_T3));
        edge_wait();
        chk("skip_seq_err", 32'(bus.seq_err), 32'h1);
        do_reset();
        chk("clr_seq_err", 32'(bus.seq_err), 32'h0);

        // Two-hot state
        drive(6'b000011, 4'h0); #1 chk("twohot_cw", 32'(cw), 32'h0);
        edge_wait();
        chk("twohot_seq_err", 32'(bus.seq_err), 32'h1);
        do_reset();

        // First sample after clr must be t1
        drive(6'b000010, 4'h0); edge_wait();
        chk("start_t2_seq_err", 32'(bus.seq_err), 32'h1);
        do_reset();
        chk("clr_seq_err2", 32'(bus.seq_err), 32'h0);

        // Counter wrap
        for (int i = 0; i < 256; i++) begin
            instr("wrap", 4'h0, W_LD4, W_LD5, 12'h000);
            if (i == 254)
                chk("wrap_255", 32'(bus.instr_count), 32'd255);
        end
        chk("wrap_count", 32'(bus.instr_count), 32'h0);
        chk("wrap_seq_err", 32'(bus.seq_err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
